i2c_master: RTL and testbench

Byte-oriented I2C initiator that drives the external I2C bus from the FPGA fabric clock. It issues single-register write transactions (START, addr+W, index, data, STOP) and single-register read transactions (START, addr+W, index, RESTART, addr+R, data with NACK, STOP). These use the same framing our register-file slave answers, so firmware-side configuration of peripherals (DACs, sensors) and loopback of our own slave both go through it.

---
 rtl/i2c_master_pkg.sv | 42 ++++
 rtl/i2c_quarter_tick.sv | 29 ++
 rtl/i2c_master.sv | 140 ++++++++++++++
 tb/tb_i2c_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C initiator: state encoding, default divider and
// the per-state open-drain drive table.
package i2c_master_pkg;

  localparam int I2C_CLK_DIV_DEFAULT = 30;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR_W, ST_INDEX, ST_WDATA,
    ST_RESTART, ST_ADDR_R, ST_RDATA, ST_STOP
  } state_t;

  // Returns {scl_lo, sda_lo} for a given bus step and quarter; 1 = pull low.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q,
                                           logic [3:0] bit_cnt, logic [7:0] tx);
    logic scl_lo, sda_lo;
    scl_lo = 1'b0;
    sda_lo = 1'b0;
    case (st)
      ST_START: begin
        sda_lo = q[1];
        scl_lo = (q == 2'd3);
      end
      ST_RESTART: begin
        scl_lo = (q == 2'd0) || (q == 2'd3);
        sda_lo = q[1];
      end
      ST_STOP: begin
        scl_lo = (q == 2'd0);
        sda_lo = (q != 2'd3);
      end
      ST_ADDR_W, ST_INDEX, ST_WDATA, ST_ADDR_R: begin
        scl_lo = !q[1];
        // bit 8 is the ack slot: always released
        sda_lo = !bit_cnt[3] && !tx[3'd7 - bit_cnt[2:0]];
      end
      ST_RDATA: scl_lo = !q[1];
      default: ;
    endcase
    return {scl_lo, sda_lo};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: CLK_DIV down-counter with a strobe on the last cycle of
// each quarter and a wrapping 2-bit quarter index. Held cleared while clr is high.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= 16'(CLK_DIV - 1);
      quarter <= 2'd0;
    end else if (cnt == 16'd0) begin
      cnt     <= 16'(CLK_DIV - 1);
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = (cnt == 16'd0);

endmodule

// File: rtl/i2c_master.sv
// Byte-oriented I2C initiator for single-register writes and reads
// (START, addr+W, index, [data | RESTART, addr+R, data+NACK], STOP).
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = I2C_CLK_DIV_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_index,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_error,
  output logic [7:0] o_rdata,
  output logic       SCL,
  inout  wire        SDA
);

  state_t     state, ns;
  logic [3:0] bit_cnt, nb;
  logic [7:0] tx_byte, ntx;
  logic [1:0] nq;
  logic [7:0] rx_byte;
  logic       nack;
  logic       scl_lo, sda_lo;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] index_q, wdata_q;
  logic       tick, step_end, sample, in_byte, sda_in;
  logic [1:0] quarter;

  assign SCL    = scl_lo ? 1'b0 : 1'bz;
  assign SDA    = sda_lo ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (CLK),
    .rst     (RST),
    .clr     (state == ST_IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  assign step_end = tick && (quarter == 2'd3);
  assign sample   = tick && (quarter == 2'd2);
  assign in_byte  = state inside {ST_ADDR_W, ST_INDEX, ST_WDATA, ST_ADDR_R, ST_RDATA};

  always_comb begin
    ns  = state;
    nb  = bit_cnt;
    ntx = tx_byte;
    case (state)
      ST_IDLE:    if (i_start && !o_done) ns = ST_START;
      ST_START: if (step_end) begin
        ns  = ST_ADDR_W;
        nb  = 4'd0;
        ntx = {addr_q, 1'b0};
      end
      ST_RESTART: if (step_end) begin
        ns  = ST_ADDR_R;
        nb  = 4'd0;
        ntx = {addr_q, 1'b1};
      end
      ST_STOP:    if (step_end) ns = ST_IDLE;
      default: if (step_end) begin
        if (!bit_cnt[3]) begin
          nb = bit_cnt + 4'd1;
        end else begin
          nb = 4'd0;
          if (state != ST_RDATA && nack) begin
            ns = ST_STOP;
          end else begin
            case (state)
              ST_ADDR_W: begin
                ns  = ST_INDEX;
                ntx = index_q;
              end
              ST_INDEX: begin
                ns  = rw_q ? ST_RESTART : ST_WDATA;
                ntx = wdata_q;
              end
              ST_ADDR_R: ns = ST_RDATA;
              default:   ns = ST_STOP;
            endcase
          end
        end
      end
    endcase
    nq = (state == ST_IDLE) ? 2'd0 : quarter + 2'(tick);
  end

  // Line drive is computed from the next step/quarter so the pins come straight off flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      tx_byte     <= 8'd0;
      rx_byte     <= 8'd0;
      nack        <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      index_q     <= 8'd0;
      wdata_q     <= 8'd0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_ack_error <= 1'b0;
      o_rdata     <= 8'd0;
      scl_lo      <= 1'b0;
      sda_lo      <= 1'b0;
    end else begin
      state              <= ns;
      bit_cnt            <= nb;
      tx_byte            <= ntx;
      {scl_lo, sda_lo}   <= bus_drive(ns, nq, nb, ntx);
      o_done             <= (state == ST_STOP) && step_end;
      if (state == ST_IDLE && ns == ST_START) begin
        rw_q        <= i_rw;
        addr_q      <= i_dev_addr;
        index_q     <= i_reg_index;
        wdata_q     <= i_wdata;
        o_ack_error <= 1'b0;
        o_busy      <= 1'b1;
      end
      if (state == ST_STOP && step_end) o_busy <= 1'b0;
      if (in_byte && sample) begin
        if (!bit_cnt[3]) rx_byte <= {rx_byte[6:0], sda_in};
        else             nack    <= sda_in;
      end
      if (in_byte && step_end && bit_cnt[3]) begin
        if (state == ST_RDATA) o_rdata     <= rx_byte;
        else if (nack)         o_ack_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two initiators (CLK_DIV 2 and 1) share one pulled-up bus
// with a register-file slave at 0x55; a cycle model predicts busy/done/error/rdata.
module tb_i2c_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] idx, wdata;
  logic [1:0] busy, done, aerr;
  logic [7:0] rdata0, rdata1;
  logic       slv_sda_lo;

  wire SCL, SDA;
  pullup (SCL);
  pullup (SDA);
  assign SDA = slv_sda_lo ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(2)) u_dut0 (
    .CLK(clk), .RST(rst), .i_start(start[0]), .i_rw(rw), .i_dev_addr(addr),
    .i_reg_index(idx), .i_wdata(wdata), .o_busy(busy[0]), .o_done(done[0]),
    .o_ack_error(aerr[0]), .o_rdata(rdata0), .SCL(SCL), .SDA(SDA));

  i2c_master #(.CLK_DIV(1)) u_dut1 (
    .CLK(clk), .RST(rst), .i_start(start[1]), .i_rw(rw), .i_dev_addr(addr),
    .i_reg_index(idx), .i_wdata(wdata), .o_busy(busy[1]), .o_done(done[1]),
    .o_ack_error(aerr[1]), .o_rdata(rdata1), .SCL(SCL), .SDA(SDA));

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Bus slave: register file at 0x55; log holds 1000=START, 1001=STOP,
  // byte values with +256 when the ack slot was high.
  logic [7:0] regs [256];
  int         log_q[$];
  bit         pscl = 1'b1, psda = 1'b1;
  int         bitn = 0, bidx = 0;
  logic [7:0] sh = 8'd0, txb = 8'd0, ptr = 8'd0;
  bit         addressed = 1'b0, rdm = 1'b0, stx = 1'b0;

  always @(negedge clk) begin
    bit scl, sda;
    scl = (SCL !== 1'b0);
    sda = (SDA !== 1'b0);
    if (pscl && scl && psda && !sda) begin
      log_q.push_back(1000);
      bitn = 0; bidx = 0; stx = 1'b0; slv_sda_lo = 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      log_q.push_back(1001);
      bitn = 0; addressed = 1'b0; stx = 1'b0; slv_sda_lo = 1'b0;
    end else if (!pscl && scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], sda};
        bitn++;
      end else if (bitn == 8) begin
        log_q.push_back(int'(sh) + (sda ? 256 : 0));
        bitn = 9;
      end
    end else if (pscl && !scl) begin
      if (bitn == 8) begin
        if (stx) slv_sda_lo = 1'b0;
        else if (bidx == 0) begin
          addressed  = (sh[7:1] == 7'h55);
          rdm        = sh[0];
          slv_sda_lo = addressed;
        end else if (addressed) begin
          if (bidx == 1) ptr = sh;
          else           regs[ptr] = sh;
          slv_sda_lo = 1'b1;
        end else slv_sda_lo = 1'b0;
      end else if (bitn == 9) begin
        stx  = addressed && rdm && (bidx == 0);
        bidx++;
        bitn = 0;
        txb  = regs[ptr];
        slv_sda_lo = stx && !txb[7];
      end else if (stx && bitn >= 1) begin
        slv_sda_lo = !txb[7 - bitn];
      end
    end
    pscl = scl;
    psda = sda;
  end

  // Cycle model: a transaction is a count of 4*CLK_DIV-cycle bus steps; busy covers
  // exactly those cycles after the accept, done is the next one.
  int         mn[2]   = '{-1, -1};
  int         mlen[2] = '{0, 0};
  bit         mpend[2], merr[2], perr[2];
  logic [7:0] mrd[2], prd[2];
  int         cdiv[2] = '{2, 1};

  function automatic int txn_steps(bit r, logic [6:0] a);
    if (a != 7'h55) return 11;
    return r ? 39 : 29;
  endfunction

  always @(negedge clk) if (chk_en) begin
    for (int d = 0; d < 2; d++) begin
      logic [7:0] rd;
      rd = (d == 0) ? rdata0 : rdata1;
      if (mpend[d]) begin
        mn[d] = 1;
        mpend[d] = 1'b0;
      end else if (mn[d] > 0) mn[d]++;
      chk($sformatf("busy%0d", d), int'(busy[d]), int'(mn[d] >= 1 && mn[d] <= mlen[d]));
      chk($sformatf("done%0d", d), int'(done[d]), int'(mn[d] == mlen[d] + 1));
      if (mn[d] == mlen[d] + 1) begin
        merr[d] = perr[d];
        mrd[d]  = prd[d];
      end
      if (mn[d] < 0 || mn[d] == mlen[d] + 1) begin
        chk($sformatf("ack_err%0d", d), int'(aerr[d]), int'(merr[d]));
        chk($sformatf("rdata%0d", d), int'(rd), int'(mrd[d]));
      end
      if (rst) begin
        mn[d] = -1; mpend[d] = 1'b0; merr[d] = 1'b0; mrd[d] = 8'd0;
      end else begin
        if (mn[d] < 0 && start[d]) begin
          mpend[d] = 1'b1;
          mlen[d]  = txn_steps(rw, addr) * 4 * cdiv[d];
          perr[d]  = (addr != 7'h55);
          prd[d]   = (rw && addr == 7'h55) ? regs[idx] : mrd[d];
        end
        if (mn[d] == mlen[d] + 1) mn[d] = -1;
      end
    end
  end

  task automatic go(int d, bit r, logic [6:0] a, logic [7:0] ix, logic [7:0] wd);
    @(posedge clk); #1;
    rw = r; addr = a; idx = ix; wdata = wd; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_done(int d, output int bcyc);
    bit got = 1'b0;
    bcyc = 0;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge clk);
      if (busy[d]) bcyc++;
      if (done[d]) got = 1'b1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout%0d: got no done, want done within 5000 cycles", d);
    end
  endtask

  task automatic chk_log(string nm, input int exp[$]);
    chk({nm, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), log_q[i], exp[i]);
  endtask

  initial begin
    int bc, k;
    int q[$];
    for (int i = 0; i < 256; i++) regs[i] = 8'd0;
    slv_sda_lo = 1'b0;
    rst = 1'b1; start = 2'b00; rw = 1'b0; addr = 7'd0; idx = 8'd0; wdata = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_err", int'(aerr[0]), 0);
    chk("rst_rdata", int'(rdata0), 0);
    chk("rst_scl", int'(SCL !== 1'b0), 1);
    chk("rst_sda", int'(SDA !== 1'b0), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // register write, all bytes acked
    log_q.delete();
    go(0, 1'b0, 7'h55, 8'h03, 8'h57);
    wait_done(0, bc);
    chk("wr_cycles", bc, 232);
    q = {1000, 'hAA, 'h03, 'h57, 1001};
    chk_log("wr_log", q);
    chk("wr_reg3", int'(regs[3]), 'h57);
    chk("wr_err", int'(aerr[0]), 0);

    // register read with RESTART and master NACK
    log_q.delete();
    go(0, 1'b1, 7'h55, 8'h03, 8'h00);
    wait_done(0, bc);
    chk("rd_cycles", bc, 312);
    q = {1000, 'hAA, 'h03, 1000, 'hAB, 'h157, 1001};
    chk_log("rd_log", q);
    chk("rd_data", int'(rdata0), 'h57);

    // address with no responder
    log_q.delete();
    go(0, 1'b0, 7'h22, 8'h10, 8'h99);
    wait_done(0, bc);
    chk("nack_cycles", bc, 88);
    q = {1000, 'h144, 1001};
    chk_log("nack_log", q);
    chk("nack_err", int'(aerr[0]), 1);
    chk("nack_rdata", int'(rdata0), 'h57);

    // start pulses while busy and on the done cycle are ignored
    log_q.delete();
    go(0, 1'b0, 7'h55, 8'h07, 8'h3C);
    for (int p = 0; p < 10; p++) begin
      repeat (5 + 3 * p) @(posedge clk);
      #1 start[0] = 1'b1; addr = 7'h22;
      @(posedge clk); #1 start[0] = 1'b0;
    end
    k = 0;
    while (k < 1000 && !(mn[0] == mlen[0] && mlen[0] > 0)) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 1000) begin
      tests++; fails++;
      $display("FAIL pulse_timeout: got no end of transfer, want one within 1000 cycles");
    end
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("pulse_idle", int'(busy[0]), 0);
    q = {1000, 'hAA, 'h07, 'h3C, 1001};
    chk_log("pulse_log", q);
    chk("pulse_reg7", int'(regs[7]), 'h3C);

    // reset during the index byte
    go(0, 1'b0, 7'h55, 8'h09, 8'h11);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_scl", int'(SCL !== 1'b0), 1);
    chk("abort_sda", int'(SDA !== 1'b0), 1);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    repeat (10) @(negedge clk);
    log_q.delete();
    go(0, 1'b0, 7'h55, 8'h0A, 8'h5A);
    wait_done(0, bc);
    chk("post_abort_cycles", bc, 232);
    q = {1000, 'hAA, 'h0A, 'h5A, 1001};
    chk_log("post_abort_log", q);

    // fastest divider
    log_q.delete();
    go(1, 1'b0, 7'h55, 8'h05, 8'hC3);
    wait_done(1, bc);
    chk("div1_cycles", bc, 116);
    q = {1000, 'hAA, 'h05, 'hC3, 1001};
    chk_log("div1_log", q);
    chk("div1_reg5", int'(regs[5]), 'hC3);
    chk("div1_err", int'(aerr[1]), 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
